// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encodings.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full-adder cell built from two half adders and an OR of their carries.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0, c0, c1;

    half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

    assign co = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused LSB first over WIDTH cycles.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             c_reg_q, c_reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] acc_next;

    full_adder_bit u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (c_reg_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; the shift form also covers WIDTH=1.
    assign acc_next = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        c_reg_d = c_reg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    c_reg_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                c_reg_d = fa_co;
                acc_d   = acc_next;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = acc_next;
                    cout_d  = fa_co;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            c_reg_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            c_reg_q <= c_reg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances against a cycle-count model.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       st [2];
    logic [7:0] av [2];
    logic [7:0] bv [2];
    logic       cv [2];
    logic       busy [2];
    logic       done [2];
    logic       cout [2];
    logic [7:0] sum8;
    logic [0:0] sum1;

    int WID [2] = '{8, 1};
    int n_vec = 0;
    int n_miss = 0;

    serial_add_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a_in(av[0]), .b_in(bv[0]), .cin(cv[0]),
        .busy(busy[0]), .done(done[0]), .sum(sum8), .cout(cout[0]));

    serial_add_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a_in(av[1][0:0]), .b_in(bv[1][0:0]),
        .cin(cv[1]), .busy(busy[1]), .done(done[1]), .sum(sum1), .cout(cout[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int dut_sum(input int i);
        return (i == 0) ? int'(sum8) : int'(sum1);
    endfunction

    // Model: an op occupies WIDTH+1 cycles after its accept edge; the result
    // appears (and done pulses) after the WIDTH-th edge following accept.
    logic m_act [2];
    int   m_el  [2];
    int   m_pend[2];
    int   m_pub [2];
    bit   model_ok = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int msk;
            msk = (1 << WID[i]) - 1;
            if (!rst_n) begin
                m_act[i] = 1'b0; m_el[i] = 0; m_pub[i] = 0;
            end else if (m_act[i]) begin
                m_el[i]++;
                if (m_el[i] == WID[i]) m_pub[i] = m_pend[i];
                if (m_el[i] == WID[i] + 1) m_act[i] = 1'b0;
            end else if (st[i]) begin
                m_act[i]  = 1'b1;
                m_el[i]   = 0;
                m_pend[i] = ((int'(av[i]) & msk) + (int'(bv[i]) & msk) + int'(cv[i]))
                            & ((msk << 1) | 1);
            end
        end
        if (!rst_n) model_ok = 1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                int msk;
                msk = (1 << WID[i]) - 1;
                chk($sformatf("w%0d_busy", WID[i]), 32'(busy[i]), 32'(m_act[i]));
                chk($sformatf("w%0d_done", WID[i]), 32'(done[i]),
                    32'(m_act[i] && m_el[i] == WID[i]));
                chk($sformatf("w%0d_sum", WID[i]), dut_sum(i), m_pub[i] & msk);
                chk($sformatf("w%0d_cout", WID[i]), 32'(cout[i]), (m_pub[i] >> WID[i]) & 1);
            end
        end
    end

    task automatic op(input int i, input int a, input int b, input int c,
                      input int es, input int ec, input string nm);
        int lat;
        @(negedge clk);
        st[i] = 1'b1; av[i] = 8'(a); bv[i] = 8'(b); cv[i] = c[0];
        @(negedge clk);
        st[i] = 1'b0; av[i] = 8'($urandom); bv[i] = 8'($urandom); cv[i] = 1'($urandom);
        lat = 1;
        while (!done[i] && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, lat, WID[i] + 1);
        chk({nm, "_sum"}, dut_sum(i), es);
        chk({nm, "_cout"}, 32'(cout[i]), ec);
    endtask

    initial begin
        logic [7:0] stab, ctab;
        int dt[$];
        int cyc;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; av[i] = '0; bv[i] = '0; cv[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_done", 32'(done[0]), 0);
        chk("rst_sum", 32'(sum8), 0);
        chk("rst_cout", 32'(cout[0]), 0);
        rst_n = 1'b1;

        op(0, 8'h00, 8'h00, 0, 8'h00, 0, "t1");
        op(0, 8'hFF, 8'h01, 0, 8'h00, 1, "t2");
        op(0, 8'hA5, 8'h5A, 1, 8'h00, 1, "t3a");
        op(0, 8'h3C, 8'h42, 0, 8'h7E, 0, "t3b");

        // Start pulse with new operands mid-run must be ignored.
        @(negedge clk);
        st[0] = 1'b1; av[0] = 8'h10; bv[0] = 8'h20; cv[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        st[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'hFF;
        @(negedge clk);
        st[0] = 1'b0;
        chk("t4_hold", 32'(sum8), 8'h7E);
        repeat (8) @(negedge clk);
        chk("t4_sum", 32'(sum8), 8'h30);
        chk("t4_cout", 32'(cout[0]), 0);
        repeat (3) @(negedge clk);

        // Reset mid-run discards the partial result.
        @(negedge clk);
        st[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'hFF; cv[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy[0]), 0);
        chk("t5_sum", 32'(sum8), 0);
        chk("t5_cout", 32'(cout[0]), 0);
        rst_n = 1'b1;
        op(0, 8'h01, 8'h02, 0, 8'h03, 0, "t5b");

        // Start held high: back-to-back issue interval.
        @(negedge clk);
        st[0] = 1'b1; av[0] = 8'h11; bv[0] = 8'h22; cv[0] = 1'b0;
        cyc = 0;
        repeat (34) begin
            @(negedge clk);
            cyc++;
            if (done[0]) dt.push_back(cyc);
        end
        st[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("t6_count", dt.size(), 3);
        if (dt.size() >= 3) begin
            chk("t6_gap1", dt[1] - dt[0], 10);
            chk("t6_gap2", dt[2] - dt[1], 10);
        end
        chk("t6_sum", 32'(sum8), 8'h33);

        // WIDTH=1 truth table.
        stab = 8'b1001_0110;
        ctab = 8'b1110_1000;
        for (int k = 0; k < 8; k++)
            op(1, (k >> 2) & 1, (k >> 1) & 1, k & 1, int'(stab[k]), int'(ctab[k]),
               $sformatf("fa%0d", k));

        // Random traffic on both instances, with occasional resets.
        for (int n = 0; n < 900; n++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 2; i++) begin
                st[i] = ($urandom_range(0, 3) == 0);
                av[i] = 8'($urandom);
                bv[i] = 8'($urandom);
                cv[i] = 1'($urandom);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        st[0] = 1'b0; st[1] = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
